proc_rst_sequencer: RTL and testbench

//  Parametrised N-stage reset release/assert sequencer on slowest_sync_clk. Runs downstream of the low-pass filter, consuming its lpf_rst_n.

---
 rtl/proc_rst_sequencer_if.sv | 33 +++
 rtl/proc_rst_sequencer.sv | 171 +++++++++++++++++
 tb/tb_proc_rst_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_rst_sequencer_if.sv
// Handshake and reset-output bundle between a requester/consumer and the
// reset sequencer. The sequencer connects through the slave modport.
interface proc_rst_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  hold_in;
    logic                  soft_rst_req;
    logic                  soft_rst_ack;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  seq_busy;
    logic                  seq_done;

    modport master (
        output hold_in,
        output soft_rst_req,
        input  soft_rst_ack,
        input  stage_rst_n,
        input  stage_rst,
        input  seq_busy,
        input  seq_done
    );

    modport slave (
        input  hold_in,
        input  soft_rst_req,
        output soft_rst_ack,
        output stage_rst_n,
        output stage_rst,
        output seq_busy,
        output seq_done
    );
endinterface

// File: rtl/proc_rst_sequencer.sv
// N-stage reset sequencer. Releases stage resets in ascending order with a
// per-stage wait, re-asserts them in reverse order on a software request,
// and parks everything in HOLD while the clock is not locked.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_RELEASE | counting down the wait of stage idx, then releasing it
// S_RUN     | all stages released, watching hold_in and soft_rst_req
// S_ASSERT  | asserting stage idx this cycle, walking down to stage 0
// S_HOLD    | all stages asserted, counting SOFT_HOLD cycles before release
module proc_rst_sequencer #(
    parameter int                          NUM_STAGES     = 3,
    parameter int                          WAIT_W         = 8,
    parameter logic [NUM_STAGES*WAIT_W-1:0] STAGE_WAIT_VEC = {8'd10, 8'd10, 8'd10},
    parameter int                          SOFT_HOLD      = 16
) (
    input logic                 slowest_sync_clk,
    input logic                 lpf_rst_n,
    proc_rst_sequencer_if.slave sif
);

    localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int HOLD_W = $clog2(SOFT_HOLD + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0]  FIRST_IDX = '0;
    localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SOFT_HOLD);

    typedef enum logic [1:0] {
        S_RELEASE,
        S_RUN,
        S_ASSERT,
        S_HOLD
    } state_t;

    // A zero wait field still costs one cycle so every stage gets a real edge.
    function automatic logic [WAIT_W-1:0] wait_of(input logic [IDX_W-1:0] i);
        logic [WAIT_W-1:0] w;
        w = STAGE_WAIT_VEC[int'(i)*WAIT_W +: WAIT_W];
        return (w == '0) ? CNT_ONE : w;
    endfunction

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic [HOLD_W-1:0]     hcnt_q, hcnt_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  pend_q, pend_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // State, counters and every output are registered here.
    always_ff @(posedge slowest_sync_clk or negedge lpf_rst_n) begin
        if (!lpf_rst_n) begin
            state_q <= S_RELEASE;
            idx_q   <= FIRST_IDX;
            cnt_q   <= wait_of(FIRST_IDX);
            hcnt_q  <= HOLD_INIT;
            rst_n_q <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            rst_n_q <= rst_n_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter and next-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        rst_n_d = rst_n_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;

        unique case (state_q)
            S_RELEASE: begin
                if (sif.hold_in) begin
                    // Abort: no partially released stage survives a hold.
                    rst_n_d = '0;
                    hcnt_d  = HOLD_INIT;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_ONE) begin
                    rst_n_d[idx_q] = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RUN;
                        ack_d   = pend_q;
                        pend_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = wait_of(idx_q + 1'b1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_RUN: begin
                if (sif.hold_in) begin
                    rst_n_d = '0;
                    hcnt_d  = HOLD_INIT;
                    state_d = S_HOLD;
                end else if (sif.soft_rst_req) begin
                    idx_d   = LAST_IDX;
                    pend_d  = 1'b1;
                    state_d = S_ASSERT;
                end
            end

            S_ASSERT: begin
                if (sif.hold_in) begin
                    rst_n_d = '0;
                    hcnt_d  = HOLD_INIT;
                    state_d = S_HOLD;
                end else begin
                    rst_n_d[idx_q] = 1'b0;
                    if (idx_q == FIRST_IDX) begin
                        hcnt_d  = HOLD_INIT;
                        state_d = S_HOLD;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end

            S_HOLD: begin
                rst_n_d = '0;
                if (sif.hold_in) begin
                    hcnt_d = HOLD_INIT;
                end else if (hcnt_q == HOLD_ONE) begin
                    idx_d   = FIRST_IDX;
                    cnt_d   = wait_of(FIRST_IDX);
                    state_d = S_RELEASE;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end

            default: begin
                rst_n_d = '0;
                idx_d   = FIRST_IDX;
                cnt_d   = wait_of(FIRST_IDX);
                state_d = S_RELEASE;
            end
        endcase

        busy_d = (state_d != S_RUN);
        done_d = (state_d == S_RUN);
    end

    assign sif.stage_rst_n  = rst_n_q;
    assign sif.stage_rst    = ~rst_n_q;
    assign sif.soft_rst_ack = ack_q;
    assign sif.seq_busy     = busy_q;
    assign sif.seq_done     = done_q;

endmodule

// File: tb/tb_proc_rst_sequencer.sv
// Directed bench for the reset sequencer: POR timing, soft request, hold
// abort, async reset abort, sticky request and two parameter variants.
module tb_proc_rst_sequencer;

    logic slowest_sync_clk = 1'b0;
    logic lpf_rst_n;
    logic rst_n1;
    logic rst_n4;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    int base;
    int n;

    always #5 slowest_sync_clk = ~slowest_sync_clk;

    proc_rst_sequencer_if #(.NUM_STAGES(3)) m_if ();
    proc_rst_sequencer_if #(.NUM_STAGES(1)) p1_if ();
    proc_rst_sequencer_if #(.NUM_STAGES(4)) p4_if ();

    proc_rst_sequencer dut (
        .slowest_sync_clk (slowest_sync_clk),
        .lpf_rst_n        (lpf_rst_n),
        .sif              (m_if.slave)
    );

    proc_rst_sequencer #(
        .NUM_STAGES     (1),
        .WAIT_W         (8),
        .STAGE_WAIT_VEC ({8'd0}),
        .SOFT_HOLD      (16)
    ) dut_n1 (
        .slowest_sync_clk (slowest_sync_clk),
        .lpf_rst_n        (rst_n1),
        .sif              (p1_if.slave)
    );

    proc_rst_sequencer #(
        .NUM_STAGES     (4),
        .WAIT_W         (8),
        .STAGE_WAIT_VEC ({8'd3, 8'd0, 8'd7, 8'd255}),
        .SOFT_HOLD      (16)
    ) dut_n4 (
        .slowest_sync_clk (slowest_sync_clk),
        .lpf_rst_n        (rst_n4),
        .sif              (p4_if.slave)
    );

    // Count ack pulses of the main instance, sampled away from the active edge.
    always @(negedge slowest_sync_clk) begin
        if (m_if.soft_rst_ack === 1'b1) ack_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge slowest_sync_clk);
        #1;
    endtask

    function automatic logic [31:0] stage_of(input int sel);
        case (sel)
            0:       return 32'(m_if.stage_rst_n);
            1:       return 32'(p1_if.stage_rst_n);
            default: return 32'(p4_if.stage_rst_n);
        endcase
    endfunction

    // Edges until stage_rst_n of the selected instance changes; limit+1 on timeout.
    task automatic wait_change(input int sel, input int limit, output int cnt);
        logic [31:0] start;
        start = stage_of(sel);
        cnt   = 0;
        while (cnt <= limit) begin
            tick();
            cnt++;
            if (stage_of(sel) !== start) return;
        end
    endtask

    task automatic expect_step(input string tag, input int sel, input int gap, input logic [31:0] val);
        int k;
        wait_change(sel, gap + 20, k);
        check_val({tag, "_gap"}, k, gap);
        check_val({tag, "_val"}, stage_of(sel), val);
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        while (cnt <= limit) begin
            tick();
            cnt++;
            if (m_if.seq_done === 1'b1) return;
        end
    endtask

    initial begin
        lpf_rst_n           = 1'b0;
        rst_n1              = 1'b0;
        rst_n4              = 1'b0;
        m_if.hold_in        = 1'b0;
        m_if.soft_rst_req   = 1'b0;
        p1_if.hold_in       = 1'b0;
        p1_if.soft_rst_req  = 1'b0;
        p4_if.hold_in       = 1'b0;
        p4_if.soft_rst_req  = 1'b0;
        repeat (3) tick();

        check_val("rst_stage_n", 32'(m_if.stage_rst_n), 32'h0);
        check_val("rst_stage",   32'(m_if.stage_rst), 32'h7);
        check_val("rst_ack",     32'(m_if.soft_rst_ack), 32'h0);
        check_val("rst_busy",    32'(m_if.seq_busy), 32'h1);
        check_val("rst_done",    32'(m_if.seq_done), 32'h0);

        // T1 power-on release
        base = ack_cnt;
        lpf_rst_n = 1'b1;
        expect_step("t1_s0", 0, 10, 32'h1);
        expect_step("t1_s1", 0, 10, 32'h3);
        expect_step("t1_s2", 0, 10, 32'h7);
        check_val("t1_done", 32'(m_if.seq_done), 32'h1);
        check_val("t1_busy", 32'(m_if.seq_busy), 32'h0);
        check_val("t1_stage_inv", 32'(m_if.stage_rst), 32'h0);
        tick();
        check_val("t1_no_ack", ack_cnt - base, 0);

        // T2 soft request pulse
        base = ack_cnt;
        m_if.soft_rst_req = 1'b1;
        tick();
        m_if.soft_rst_req = 1'b0;
        check_val("t2_busy", 32'(m_if.seq_busy), 32'h1);
        check_val("t2_done", 32'(m_if.seq_done), 32'h0);
        check_val("t2_still", stage_of(0), 32'h7);
        expect_step("t2_a2", 0, 1, 32'h3);
        expect_step("t2_a1", 0, 1, 32'h1);
        expect_step("t2_a0", 0, 1, 32'h0);
        expect_step("t2_r0", 0, 26, 32'h1);
        expect_step("t2_r1", 0, 10, 32'h3);
        expect_step("t2_r2", 0, 10, 32'h7);
        check_val("t2_ack_hi", 32'(m_if.soft_rst_ack), 32'h1);
        check_val("t2_done_hi", 32'(m_if.seq_done), 32'h1);
        tick();
        check_val("t2_ack_lo", 32'(m_if.soft_rst_ack), 32'h0);
        check_val("t2_ack_cnt", ack_cnt - base, 1);

        // hold_in wins over soft_rst_req in RUN
        base = ack_cnt;
        m_if.hold_in      = 1'b1;
        m_if.soft_rst_req = 1'b1;
        tick();
        m_if.hold_in      = 1'b0;
        m_if.soft_rst_req = 1'b0;
        check_val("prio_all", stage_of(0), 32'h0);
        expect_step("prio_r0", 0, 26, 32'h1);
        expect_step("prio_r1", 0, 10, 32'h3);
        expect_step("prio_r2", 0, 10, 32'h7);
        tick();
        check_val("prio_no_ack", ack_cnt - base, 0);

        // T3 hold during RELEASE of stage 1
        base = ack_cnt;
        lpf_rst_n = 1'b0;
        tick();
        lpf_rst_n = 1'b1;
        expect_step("t3_s0", 0, 10, 32'h1);
        repeat (3) tick();
        m_if.hold_in = 1'b1;
        expect_step("t3_abort", 0, 1, 32'h0);
        repeat (4) tick();
        m_if.hold_in = 1'b0;
        check_val("t3_busy", 32'(m_if.seq_busy), 32'h1);
        expect_step("t3_r0", 0, 26, 32'h1);
        expect_step("t3_r1", 0, 10, 32'h3);
        expect_step("t3_r2", 0, 10, 32'h7);
        tick();
        check_val("t3_no_ack", ack_cnt - base, 0);

        // T4 async reset in the middle of a soft sequence HOLD
        base = ack_cnt;
        m_if.soft_rst_req = 1'b1;
        tick();
        m_if.soft_rst_req = 1'b0;
        repeat (8) tick();
        lpf_rst_n = 1'b0;
        #1;
        check_val("t4_stage_n", 32'(m_if.stage_rst_n), 32'h0);
        check_val("t4_stage",   32'(m_if.stage_rst), 32'h7);
        check_val("t4_busy",    32'(m_if.seq_busy), 32'h1);
        check_val("t4_done",    32'(m_if.seq_done), 32'h0);
        tick();
        lpf_rst_n = 1'b1;
        expect_step("t4_s0", 0, 10, 32'h1);
        expect_step("t4_s1", 0, 10, 32'h3);
        expect_step("t4_s2", 0, 10, 32'h7);
        tick();
        check_val("t4_no_ack", ack_cnt - base, 0);

        // T6 sticky request: back-to-back sequences
        base = ack_cnt;
        m_if.soft_rst_req = 1'b1;
        expect_step("t6_a2", 0, 2, 32'h3);
        wait_done(80, n);
        check_val("t6_seq1_len", n, 48);
        check_val("t6_ack1", 32'(m_if.soft_rst_ack), 32'h1);
        tick();
        check_val("t6_restart_done", 32'(m_if.seq_done), 32'h0);
        check_val("t6_restart_busy", 32'(m_if.seq_busy), 32'h1);
        check_val("t6_ack1_lo", 32'(m_if.soft_rst_ack), 32'h0);
        wait_done(80, n);
        check_val("t6_seq2_len", n, 49);
        check_val("t6_ack2", 32'(m_if.soft_rst_ack), 32'h1);
        m_if.soft_rst_req = 1'b0;
        tick();
        check_val("t6_stay_run", 32'(m_if.seq_done), 32'h1);
        check_val("t6_ack_cnt", ack_cnt - base, 2);

        // T5 parameter variants
        rst_n1 = 1'b1;
        expect_step("t5_n1_s0", 1, 1, 32'h1);
        check_val("t5_n1_done", 32'(p1_if.seq_done), 32'h1);
        rst_n4 = 1'b1;
        expect_step("t5_n4_s0", 2, 255, 32'h1);
        expect_step("t5_n4_s1", 2, 7, 32'h3);
        expect_step("t5_n4_s2", 2, 1, 32'h7);
        expect_step("t5_n4_s3", 2, 3, 32'hf);
        check_val("t5_n4_done", 32'(p4_if.seq_done), 32'h1);
        check_val("t5_n4_inv", 32'(p4_if.stage_rst), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
